// File: rtl/ls_array_ctrl.sv
// ls_array_ctrl: load/store array sequencer feeding the MXU.
// For each tile it fetches ROWS weight words (one outstanding request at a
// time) into the row load units, pops cfg_cols activation words from the
// input FIFO into the column registers, fires the MXU and reports done.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   start, abort              tile start pulse (IDLE only) / abort to IDLE
//   cfg_cols, cfg_wbase       tile config, latched on an accepted start
//   wmem_req/addr/gnt/valid   weight memory read port
//   row_load_en               one-hot row load strobe (with wmem_valid)
//   infifo_empty/read         activation FIFO status / pop
//   load_in_reg, col_sel      activation register load strobe, one-hot column
//   mxu_start, mxu_done       MXU fire pulse / completion
//   busy, done                not-IDLE flag / one-cycle tile-complete pulse
//   stall_cycles              only with LS_CTRL_STALL_CNT_EN defined
//
// Optional feature macro: LS_CTRL_STALL_CNT_EN adds the saturating
// stall_cycles counter (W_REQ without grant plus A_LOAD with empty FIFO).

module ls_array_ctrl #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLUMNS    = 4,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [$clog2(COLUMNS):0]    cfg_cols,
    input  logic [ADDR_WIDTH-1:0]       cfg_wbase,
    output logic                        wmem_req,
    output logic [ADDR_WIDTH-1:0]       wmem_addr,
    input  logic                        wmem_gnt,
    input  logic                        wmem_valid,
    output logic [ROWS-1:0]             row_load_en,
    input  logic                        infifo_empty,
    output logic                        infifo_read,
    output logic                        load_in_reg,
    output logic [COLUMNS-1:0]          col_sel,
    output logic                        mxu_start,
    input  logic                        mxu_done,
    output logic                        busy,
`ifdef LS_CTRL_STALL_CNT_EN
    output logic [31:0]                 stall_cycles,
`endif
    output logic                        done
);

    localparam int unsigned CW = $clog2(COLUMNS) + 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_REQ    = 3'd1,
        W_WAIT   = 3'd2,
        A_LOAD   = 3'd3,
        FIRE     = 3'd4,
        WAIT_MXU = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                  state, state_d;
    logic [RW-1:0]           row_cnt, row_cnt_d;
    logic [CW-1:0]           col_cnt, col_cnt_d;
    logic [CW-1:0]           cols_q, cols_d;
    logic [ADDR_WIDTH-1:0]   wbase_q, wbase_d;
    logic                    start_ok;

    // A start is only taken in IDLE and loses to a simultaneous abort.
    assign start_ok = (state == IDLE) && start && !abort;

    // State and tile-context registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            row_cnt <= '0;
            col_cnt <= '0;
            cols_q  <= '0;
            wbase_q <= '0;
        end else begin
            state   <= state_d;
            row_cnt <= row_cnt_d;
            col_cnt <= col_cnt_d;
            cols_q  <= cols_d;
            wbase_q <= wbase_d;
        end
    end

    // Next-state, counter updates and output decode.
    always_comb begin
        state_d     = state;
        row_cnt_d   = row_cnt;
        col_cnt_d   = col_cnt;
        cols_d      = cols_q;
        wbase_d     = wbase_q;
        wmem_req    = 1'b0;
        wmem_addr   = '0;
        row_load_en = '0;
        infifo_read = 1'b0;
        col_sel     = '0;
        mxu_start   = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (start_ok) begin
                    // Zero or out-of-range column counts mean a full tile.
                    if ((cfg_cols == '0) || (32'(cfg_cols) > COLUMNS)) begin
                        cols_d = CW'(COLUMNS);
                    end else begin
                        cols_d = cfg_cols;
                    end
                    wbase_d   = cfg_wbase;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                    state_d   = W_REQ;
                end
            end

            W_REQ: begin
                // Request and address held stable until granted.
                wmem_req  = 1'b1;
                wmem_addr = wbase_q + ADDR_WIDTH'(row_cnt);
                if (wmem_gnt) begin
                    state_d = W_WAIT;
                end
            end

            W_WAIT: begin
                // An aborted response is dropped rather than loaded.
                if (wmem_valid && !abort) begin
                    row_load_en = ROWS'(1) << row_cnt;
                    if (row_cnt == RW'(ROWS - 1)) begin
                        state_d = A_LOAD;
                    end else begin
                        row_cnt_d = row_cnt + RW'(1);
                        state_d   = W_REQ;
                    end
                end
            end

            A_LOAD: begin
                // Empty FIFO stalls here indefinitely.
                if (!infifo_empty && !abort) begin
                    infifo_read = 1'b1;
                    col_sel     = COLUMNS'(1) << col_cnt;
                    if (col_cnt == CW'(cols_q - CW'(1))) begin
                        state_d = FIRE;
                    end else begin
                        col_cnt_d = col_cnt + CW'(1);
                    end
                end
            end

            FIRE: begin
                mxu_start = 1'b1;
                state_d   = WAIT_MXU;
            end

            WAIT_MXU: begin
                if (mxu_done) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every other transition.
        if (abort && (state != IDLE)) begin
            state_d = IDLE;
        end
    end

    assign load_in_reg = infifo_read;

`ifdef LS_CTRL_STALL_CNT_EN
    logic stall_now;

    assign stall_now = ((state == W_REQ) && !wmem_gnt) ||
                       ((state == A_LOAD) && infifo_empty);

    // Saturating stall counter, cleared per tile, frozen while IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
